hazard_ctrl: RTL and testbench

Pipeline sequencer for the 5-stage RV32 core (IF, ID, EX, MEM, WB). It drives the enable and flush controls of the PC generator and of the IF/ID, ID/EX and EX/MEM registers. It handles three events: load-use stalls, taken-branch flushes (the branch resolves in MEM) and multi-cycle data-memory waits. It also keeps stall and flush event counters and a sticky memory-timeout flag for debug.

---
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline sequencer for the 5-stage RV32 core.
//
// Drives the enable and flush controls of the PC and the IF/ID, ID/EX and
// EX/MEM registers. It handles load-use stalls, taken-branch flushes (the
// branch resolves in MEM) and multi-cycle data-memory waits. It also keeps
// saturating stall and flush counters and a sticky memory-timeout flag.
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   rs1/rs2_fr_i, use_rs*_fr_i   source operands of the IF/ID instruction
//   memread_idr_i, rd_idr_i      load flag and rd of the ID/EX instruction
//   branch_taken_exr_i           PCSrc from EX/MEM
//   dmem_req_exr_i, dmem_ready_i data-memory handshake
//   *_we_o, *_flush_o            pipeline register controls (combinational)
//   memr_bubble_o                zero the MEM/WB control bits
//   state_o                      00 RUN, 01 MEM_WAIT, 11 ERROR
//   stall_cnt_o, flush_cnt_o     debug event counters
//   timeout_o                    sticky memory timeout
module hazard_ctrl #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_fr_i,
  input  logic [4:0]       rs2_fr_i,
  input  logic             use_rs1_fr_i,
  input  logic             use_rs2_fr_i,
  input  logic             memread_idr_i,
  input  logic [4:0]       rd_idr_i,
  input  logic             branch_taken_exr_i,
  input  logic             dmem_req_exr_i,
  input  logic             dmem_ready_i,
  output logic             pc_we_o,
  output logic             fr_we_o,
  output logic             idr_we_o,
  output logic             exr_we_o,
  output logic             fr_flush_o,
  output logic             idr_flush_o,
  output logic             exr_flush_o,
  output logic             memr_bubble_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b11
  } state_e;

  localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu, mw;
  logic hold;   // freeze everything up to EX/MEM and bubble MEM/WB
  logic free;   // no memory hold: branch/lu take effect this cycle

  assign lu = memread_idr_i && (rd_idr_i != 5'd0) &&
              ((use_rs1_fr_i && (rs1_fr_i == rd_idr_i)) ||
               (use_rs2_fr_i && (rs2_fr_i == rd_idr_i)));
  assign mw = dmem_req_exr_i && !dmem_ready_i;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    hold          = 1'b0;
    free          = 1'b0;
    pc_we_o       = 1'b1;
    fr_we_o       = 1'b1;
    idr_we_o      = 1'b1;
    exr_we_o      = 1'b1;
    fr_flush_o    = 1'b0;
    idr_flush_o   = 1'b0;
    exr_flush_o   = 1'b0;
    memr_bubble_o = 1'b0;

    case (state_q)
      ERROR: hold = 1'b1;  // absorbing until reset
      MEM_WAIT: begin
        if (!dmem_ready_i) begin
          hold = 1'b1;
          if (wait_cnt_q == WAIT_MAX_C) state_d = ERROR;
          else                          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          // Release cycle: the held EX/MEM instruction (possibly a taken
          // branch) and any load-use are handled as in RUN.
          free       = 1'b1;
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end
      end
      default: begin
        if (mw) begin
          hold       = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          free = 1'b1;
        end
      end
    endcase

    if (hold) begin
      pc_we_o       = 1'b0;
      fr_we_o       = 1'b0;
      idr_we_o      = 1'b0;
      exr_we_o      = 1'b0;
      memr_bubble_o = 1'b1;
    end else if (free && branch_taken_exr_i) begin
      // PC keeps its enable to load the branch target; the younger
      // instructions are squashed, which also cancels any load-use.
      fr_flush_o  = 1'b1;
      idr_flush_o = 1'b1;
      exr_flush_o = 1'b1;
    end else if (free && lu) begin
      pc_we_o     = 1'b0;
      fr_we_o     = 1'b0;
      idr_flush_o = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_we_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (free && branch_taken_exr_i && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign timeout_o   = (state_q == ERROR);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (CNT_W=4, WAIT_MAX=4). Each cycle the
// stimulus task pushes the expected control vector, and the vector is popped
// and compared while the inputs are stable, mid-cycle.
module tb_hazard_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1, rs2, rd;
  logic             use1, use2, mrd, br, req, rdy;
  logic             pc_we, fr_we, idr_we, exr_we;
  logic             fr_fl, idr_fl, exr_fl, bub;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             timeout;

  hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .rs1_fr_i(rs1), .rs2_fr_i(rs2), .use_rs1_fr_i(use1), .use_rs2_fr_i(use2),
    .memread_idr_i(mrd), .rd_idr_i(rd), .branch_taken_exr_i(br),
    .dmem_req_exr_i(req), .dmem_ready_i(rdy),
    .pc_we_o(pc_we), .fr_we_o(fr_we), .idr_we_o(idr_we), .exr_we_o(exr_we),
    .fr_flush_o(fr_fl), .idr_flush_o(idr_fl), .exr_flush_o(exr_fl),
    .memr_bubble_o(bub), .state_o(state),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // {pc_we, fr_we, idr_we, exr_we, fr_fl, idr_fl, exr_fl, bubble, state}
  localparam logic [9:0] NORM   = 10'b1111_000_0_00;
  localparam logic [9:0] LU     = 10'b0011_010_0_00;
  localparam logic [9:0] BR     = 10'b1111_111_0_00;
  localparam logic [9:0] MW_RUN = 10'b0000_000_1_00;
  localparam logic [9:0] MW_WT  = 10'b0000_000_1_01;
  localparam logic [9:0] REL    = 10'b1111_000_0_01;
  localparam logic [9:0] REL_BR = 10'b1111_111_0_01;
  localparam logic [9:0] ERR    = 10'b0000_000_1_11;

  int errs = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ctrl();
    return {pc_we, fr_we, idr_we, exr_we, fr_fl, idr_fl, exr_fl, bub, state};
  endfunction

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    use1 = 1'b0; use2 = 1'b0; mrd = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2, input logic [4:0] d);
    rs1 = r1; use1 = u1; rs2 = r2; use2 = u2; rd = d; mrd = 1'b1;
  endtask

  // Inputs are already driven; push the expectation, compare mid-cycle,
  // then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [9:0] exp);
    logic [9:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    chk(tag, 32'(ctrl()), 32'(e));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctrl", 32'(ctrl()), 32'(NORM));
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: lw x5 ; add x6,x5,x1 -> single-cycle stall
    set_lu(5'd5, 1'b1, 5'd1, 1'b1, 5'd5);
    cyc("lu_stall", LU);
    idle();
    cyc("lu_after", NORM);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // 2: rd=0, then rs1 match without use -> no stall; rs2 match does stall
    do_reset();
    set_lu(5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    cyc("lu_rd0", NORM);
    set_lu(5'd5, 1'b0, 5'd5, 1'b0, 5'd5);
    cyc("lu_nouse", NORM);
    chk("lu_none_cnt", 32'(stall_cnt), 32'd0);
    set_lu(5'd1, 1'b1, 5'd7, 1'b1, 5'd7);
    cyc("lu_rs2", LU);
    chk("lu_rs2_cnt", 32'(stall_cnt), 32'd1);

    // 3: branch pulse with a coincident load-use
    do_reset();
    set_lu(5'd5, 1'b1, 5'd0, 1'b0, 5'd5);
    br = 1'b1;
    cyc("br_flush", BR);
    idle();
    cyc("br_after", NORM);
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd0);

    // 4: three-cycle memory wait then release
    do_reset();
    req = 1'b1; rdy = 1'b0;
    cyc("mw_c1", MW_RUN);
    cyc("mw_c2", MW_WT);
    cyc("mw_c3", MW_WT);
    rdy = 1'b1;
    cyc("mw_rel", REL);
    idle();
    cyc("mw_after", NORM);
    chk("mw_stall_cnt", 32'(stall_cnt), 32'd3);

    // 5: timeout with WAIT_MAX=4, then asynchronous reset out of ERROR
    do_reset();
    req = 1'b1; rdy = 1'b0;
    cyc("to_c1", MW_RUN);
    for (int i = 0; i < 4; i++) cyc("to_wait", MW_WT);
    chk("to_timeout", 32'(timeout), 32'd1);
    rdy = 1'b1;
    cyc("to_err1", ERR);
    idle();
    cyc("to_err2", ERR);
    chk("to_sticky", 32'(timeout), 32'd1);
    chk("to_stall_cnt", 32'(stall_cnt), 32'd7);
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_timeout", 32'(timeout), 32'd0);
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 6: stall counter saturation, then branch coincident with a memory wait
    set_lu(5'd3, 1'b1, 5'd0, 1'b0, 5'd3);
    for (int i = 0; i < 20; i++) cyc("sat_lu", LU);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    do_reset();
    br = 1'b1; req = 1'b1; rdy = 1'b0;
    cyc("brmw_c1", MW_RUN);
    cyc("brmw_c2", MW_WT);
    chk("brmw_defer", 32'(flush_cnt), 32'd0);
    rdy = 1'b1;
    cyc("brmw_rel", REL_BR);
    idle();
    cyc("brmw_after", NORM);
    chk("brmw_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("brmw_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
